// File: rtl/cpu_mem_loader.sv
// Host-side loader and run controller for the pipelined RISC-V core: streams words
// into imem/dmem, gates the core's enable for RUN, and streams dmem back out.
module cpu_mem_loader #(
  parameter int IMEM_DEPTH = 512,
  parameter int DMEM_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_addr,
  input  logic [31:0] cmd_len,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [63:0] s_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [63:0] m_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        cpu_enable,
  output logic [63:0] addr_ext,
  output logic        wen_ext,
  output logic        ren_ext,
  output logic [31:0] wdata_ext,
  output logic [63:0] addr_ext_2,
  output logic        wen_ext_2,
  output logic        ren_ext_2,
  output logic [63:0] wdata_ext_2,
  input  logic [63:0] rdata_ext_2
);
  // state | meaning
  // IDLE  | waiting for a command
  // LOAD  | accepting stream words, one registered write per beat
  // RUN   | cpu_enable high while the cycle down-counter runs
  // DREQ  | dmem read strobe for word idx
  // DCAP  | read data present on rdata_ext_2, captured into m_data
  // DOUT  | m_valid high until m_ready
  // DONE  | one-cycle done/err pulse
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    DREQ = 3'd3,
    DCAP = 3'd4,
    DOUT = 3'd5,
    DONE = 3'd6
  } state_t;

  localparam logic [1:0] OP_LOAD_I = 2'd0;
  localparam logic [1:0] OP_RUN    = 2'd2;
  localparam logic [1:0] OP_DUMP_D = 2'd3;

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [15:0] base_q, base_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] idx_q, idx_d;
  logic        err_q, err_d;

  logic        wen_q, wen2_q, ren2_q;
  logic [63:0] addr_q, addr2_q, wdata2_q, m_data_q;
  logic [31:0] wdata_q;

  logic [32:0] cmd_end, cmd_depth;
  logic        range_err;
  logic [63:0] wr_word, rd_word;

  // 33-bit end index so addr+len can never wrap past the depth compare
  assign cmd_end   = {17'd0, cmd_addr} + {1'b0, cmd_len};
  assign cmd_depth = (cmd_op == OP_LOAD_I) ? 33'(IMEM_DEPTH) : 33'(DMEM_DEPTH);
  assign range_err = (cmd_op != OP_RUN) && (cmd_end > cmd_depth);

  assign wr_word = {48'd0, base_q} + {32'd0, idx_q};
  assign rd_word = {48'd0, base_d} + {32'd0, idx_d};

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    base_d  = base_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d   = cmd_op;
          base_d = cmd_addr;
          rem_d  = cmd_len;
          idx_d  = 32'd0;
          err_d  = 1'b0;
          if (cmd_len == 32'd0) begin
            state_d = DONE;
          end else if (range_err) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            case (cmd_op)
              OP_RUN:    state_d = RUN;
              OP_DUMP_D: state_d = DREQ;
              default:   state_d = LOAD;
            endcase
          end
        end
      end
      LOAD: begin
        if (s_valid) begin
          idx_d = idx_q + 32'd1;
          rem_d = rem_q - 32'd1;
          if (rem_q == 32'd1) state_d = DONE;
        end
      end
      RUN: begin
        rem_d = rem_q - 32'd1;
        if (rem_q == 32'd1) state_d = DONE;
      end
      DREQ: state_d = DCAP;
      DCAP: state_d = DOUT;
      DOUT: begin
        if (m_ready) begin
          idx_d   = idx_q + 32'd1;
          rem_d   = rem_q - 32'd1;
          state_d = (rem_q == 32'd1) ? DONE : DREQ;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= 2'd0;
      base_q   <= 16'd0;
      rem_q    <= 32'd0;
      idx_q    <= 32'd0;
      err_q    <= 1'b0;
      wen_q    <= 1'b0;
      wen2_q   <= 1'b0;
      ren2_q   <= 1'b0;
      addr_q   <= 64'd0;
      wdata_q  <= 32'd0;
      addr2_q  <= 64'd0;
      wdata2_q <= 64'd0;
      m_data_q <= 64'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      base_q  <= base_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      wen_q   <= 1'b0;
      wen2_q  <= 1'b0;
      ren2_q  <= 1'b0;
      if (state_q == LOAD && s_valid) begin
        if (op_q == OP_LOAD_I) begin
          wen_q   <= 1'b1;
          addr_q  <= wr_word << 2;
          wdata_q <= s_data[31:0];
        end else begin
          wen2_q   <= 1'b1;
          addr2_q  <= wr_word << 3;
          wdata2_q <= s_data;
        end
      end
      // read strobe is registered on entry so it is valid for the whole DREQ cycle
      if (state_d == DREQ) begin
        ren2_q  <= 1'b1;
        addr2_q <= rd_word << 3;
      end
      if (state_q == DCAP) m_data_q <= rdata_ext_2;
    end
  end

  assign cmd_ready   = (state_q == IDLE) && !rst;
  assign s_ready     = (state_q == LOAD);
  assign m_valid     = (state_q == DOUT);
  assign m_data      = m_data_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign err         = (state_q == DONE) && err_q;
  assign cpu_enable  = (state_q == RUN);
  assign addr_ext    = addr_q;
  assign wen_ext     = wen_q;
  assign ren_ext     = 1'b0;
  assign wdata_ext   = wdata_q;
  assign addr_ext_2  = addr2_q;
  assign wen_ext_2   = wen2_q;
  assign ren_ext_2   = ren2_q;
  assign wdata_ext_2 = wdata2_q;

endmodule

// File: tb/tb_cpu_mem_loader.sv
// Scoreboard bench for cpu_mem_loader with behavioural imem/dmem and a tiny core model.
module tb_cpu_mem_loader;
  localparam logic [1:0] OP_LI = 2'd0, OP_LD = 2'd1, OP_RUN = 2'd2, OP_DUMP = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [15:0] cmd_addr = 16'd0;
  logic [31:0] cmd_len = 32'd0;
  logic        s_valid = 1'b0, s_ready;
  logic [63:0] s_data = 64'd0;
  logic        m_valid, m_ready = 1'b0;
  logic [63:0] m_data;
  logic        busy, done, err, cpu_enable;
  logic [63:0] addr_ext, addr_ext_2, wdata_ext_2;
  logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2;
  logic [31:0] wdata_ext;
  logic [63:0] rdata_ext_2 = 64'd0;

  always #5 clk = ~clk;

  cpu_mem_loader dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .busy(busy), .done(done), .err(err), .cpu_enable(cpu_enable),
    .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext),
    .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
    .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2)
  );

  // memories and a minimal core (ADDI, SD, JAL x0,0 as halt; others are no-ops)
  logic [31:0] imem [512] = '{default: 32'd0};
  logic [63:0] dmem [1024] = '{default: 64'd0};
  logic [63:0] rf [32] = '{default: 64'd0};
  logic [63:0] pc = 64'd0;
  logic [31:0] cur_inst;
  logic [63:0] rs1v, rs2v, imm_i, imm_s, ea;
  assign cur_inst = imem[pc[10:2]];
  assign rs1v  = rf[cur_inst[19:15]];
  assign rs2v  = rf[cur_inst[24:20]];
  assign imm_i = {{52{cur_inst[31]}}, cur_inst[31:20]};
  assign imm_s = {{52{cur_inst[31]}}, cur_inst[31:25], cur_inst[11:7]};
  assign ea    = rs1v + imm_s;

  always @(posedge clk) begin
    if (rst) begin
      pc <= 64'd0;
    end else begin
      if (wen_ext)   imem[addr_ext[10:2]] <= wdata_ext;
      if (wen_ext_2) dmem[addr_ext_2[12:3]] <= wdata_ext_2;
      if (ren_ext_2) rdata_ext_2 <= dmem[addr_ext_2[12:3]];
      if (cpu_enable) begin
        if (cur_inst[6:0] == 7'h13 && cur_inst[14:12] == 3'd0 && cur_inst[11:7] != 5'd0)
          rf[cur_inst[11:7]] <= rs1v + imm_i;
        if (cur_inst[6:0] == 7'h23 && cur_inst[14:12] == 3'd3)
          dmem[ea[12:3]] <= rs2v;
        if (cur_inst != 32'h0000006F) pc <= pc + 64'd4;
      end
    end
  end

  typedef struct packed {logic [63:0] addr; logic [63:0] data;} wr_t;
  typedef struct packed {logic err; logic [31:0] en; logic wr;} done_t;
  wr_t         q_iw[$], q_dw[$];
  logic [63:0] q_rd[$], q_m[$];
  done_t       q_done[$];

  int checks = 0, failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic void push_iw(input logic [63:0] a, input logic [63:0] d);
    q_iw.push_back({a, d});
  endfunction
  function automatic void push_dw(input logic [63:0] a, input logic [63:0] d);
    q_dw.push_back({a, d});
  endfunction
  function automatic void push_done(input logic e, input logic [31:0] en, input logic w);
    q_done.push_back({e, en, w});
  endfunction

  // monitor: pops expectations whenever the DUT presents an event
  initial begin
    wr_t   w;
    done_t d;
    int    en_cnt;
    logic  prev_en;
    logic [1:0] nstrobe;
    en_cnt  = 0;
    prev_en = 1'b0;
    forever begin
      @(negedge clk);
      if (wen_ext) begin
        if (q_iw.size() == 0) check("imem_wr_unexpected", 64'(wen_ext), 64'd0);
        else begin
          w = q_iw.pop_front();
          check("imem_wr_addr", addr_ext, w.addr);
          check("imem_wr_data", 64'(wdata_ext), w.data);
        end
      end
      if (wen_ext_2) begin
        if (q_dw.size() == 0) check("dmem_wr_unexpected", 64'(wen_ext_2), 64'd0);
        else begin
          w = q_dw.pop_front();
          check("dmem_wr_addr", addr_ext_2, w.addr);
          check("dmem_wr_data", wdata_ext_2, w.data);
        end
      end
      if (ren_ext_2) begin
        if (q_rd.size() == 0) check("dmem_rd_unexpected", 64'(ren_ext_2), 64'd0);
        else check("dmem_rd_addr", addr_ext_2, q_rd.pop_front());
      end
      if (m_valid) begin
        if (q_m.size() == 0) check("dump_unexpected", 64'(m_valid), 64'd0);
        else begin
          check("dump_data", m_data, q_m[0]);
          if (m_ready) void'(q_m.pop_front());
        end
      end
      nstrobe = 2'(wen_ext_2) + 2'(ren_ext_2) + 2'(cpu_enable);
      if (nstrobe != 2'd0) check("strobe_exclusive", 64'(nstrobe), 64'd1);
      if (done) begin
        if (q_done.size() == 0) check("done_unexpected", 64'(done), 64'd0);
        else begin
          d = q_done.pop_front();
          check("done_err", 64'(err), 64'(d.err));
          check("done_enable_cycles", 64'(en_cnt), 64'(d.en));
          check("done_write_strobe", 64'(wen_ext | wen_ext_2), 64'(d.wr));
          check("done_busy", 64'(busy), 64'd1);
          check("ren_ext_zero", 64'(ren_ext), 64'd0);
          if (d.en != 32'd0) check("run_enable_before_done", 64'(prev_en), 64'd1);
        end
        en_cnt = 0;
      end else if (cpu_enable) begin
        en_cnt++;
      end
      prev_en = cpu_enable;
    end
  end

  task automatic send_cmd(input logic [1:0] op, input logic [15:0] a, input logic [31:0] l);
    int n;
    n = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_len = l;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    if (!cmd_ready) check("cmd_ready_timeout", 64'(cmd_ready), 64'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic send_word(input logic [63:0] dv);
    int n;
    n = 0;
    s_valid = 1'b1; s_data = dv;
    while (!s_ready && n < 20) begin @(negedge clk); n++; end
    if (!s_ready) check("s_ready_timeout", 64'(s_ready), 64'd1);
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < bound) begin @(negedge clk); n++; end
    if (!done) check({name, "_done_timeout"}, 64'(done), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctrl"}, 64'({cmd_ready, s_ready, m_valid, busy, done, err, cpu_enable,
                                wen_ext, ren_ext, wen_ext_2, ren_ext_2}), 64'd0);
    check({name, "_addr_ext"}, addr_ext, 64'd0);
    check({name, "_wdata_ext"}, 64'(wdata_ext), 64'd0);
    check({name, "_addr_ext_2"}, addr_ext_2, 64'd0);
    check({name, "_wdata_ext_2"}, wdata_ext_2, 64'd0);
    check({name, "_m_data"}, m_data, 64'd0);
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clk); #1;
    @(negedge clk);
    check_all_zero("reset_init");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("cmd_ready_after_reset", 64'(cmd_ready), 64'd1);
    @(posedge clk); #1;

    // end-to-end: addi x1,x0,0x5A5 ; sd x1,16(x0) ; jal x0,0
    push_iw(64'd0, 64'h5A500093); push_iw(64'd4, 64'h00103823); push_iw(64'd8, 64'h0000006F);
    push_done(1'b0, 32'd0, 1'b1);
    send_cmd(OP_LI, 16'd0, 32'd3);
    check("load_s_ready_latency", 64'(s_ready), 64'd1);
    send_word(64'h5A500093); send_word(64'h00103823); send_word(64'h0000006F);
    wait_done(10, "e2e_load");
    push_done(1'b0, 32'd20, 1'b0);
    send_cmd(OP_RUN, 16'd0, 32'd20);
    wait_done(40, "e2e_run");
    q_rd.push_back(64'd16); q_m.push_back(64'h5A5); push_done(1'b0, 32'd0, 1'b0);
    m_ready = 1'b1;
    send_cmd(OP_DUMP, 16'd2, 32'd1);
    wait_done(20, "e2e_dump");

    // LOAD_I addr=3 len=4 back-to-back
    push_iw(64'd12, 64'h11); push_iw(64'd16, 64'h22); push_iw(64'd20, 64'h33); push_iw(64'd24, 64'h44);
    push_done(1'b0, 32'd0, 1'b1);
    send_cmd(OP_LI, 16'd3, 32'd4);
    send_word(64'h11); send_word(64'h22); send_word(64'h33); send_word(64'h44);
    wait_done(5, "load_i");

    // RUN len=7 and len=0
    push_done(1'b0, 32'd7, 1'b0);
    send_cmd(OP_RUN, 16'd0, 32'd7);
    @(negedge clk);
    check("run_enable_rise", 64'(cpu_enable), 64'd1);
    wait_done(20, "run7");
    push_done(1'b0, 32'd0, 1'b0);
    send_cmd(OP_RUN, 16'd0, 32'd0);
    @(negedge clk);
    check("run0_done_latency", 64'(done), 64'd1);
    @(posedge clk); #1;

    // LOAD_D range error, then the largest in-range load at the same base
    push_done(1'b1, 32'd0, 1'b0);
    send_cmd(OP_LD, 16'd1020, 32'd5);
    @(negedge clk);
    check("range_err_done_latency", 64'(done), 64'd1);
    @(posedge clk); #1;
    push_dw(64'd8160, 64'hD0); push_dw(64'd8168, 64'hD1); push_dw(64'd8176, 64'hD2);
    push_dw(64'd8184, 64'hFFFF_0000_1234_5678);
    push_done(1'b0, 32'd0, 1'b1);
    send_cmd(OP_LD, 16'd1020, 32'd4);
    send_word(64'hD0); send_word(64'hD1); send_word(64'hD2); send_word(64'hFFFF_0000_1234_5678);
    wait_done(5, "load_d_edge");

    // preload dmem[0..2] then dump with back-pressure on the second word
    push_dw(64'd0, 64'hA); push_dw(64'd8, 64'hB); push_dw(64'd16, 64'hC);
    push_done(1'b0, 32'd0, 1'b1);
    send_cmd(OP_LD, 16'd0, 32'd3);
    send_word(64'hA); send_word(64'hB); send_word(64'hC);
    wait_done(5, "load_d_pre");
    q_rd.push_back(64'd0); q_rd.push_back(64'd8); q_rd.push_back(64'd16);
    q_m.push_back(64'hA); q_m.push_back(64'hB); q_m.push_back(64'hC);
    push_done(1'b0, 32'd0, 1'b0);
    m_ready = 1'b1;
    send_cmd(OP_DUMP, 16'd0, 32'd3);
    @(negedge clk);
    check("dump_m_valid_early", 64'(m_valid), 64'd0);
    @(negedge clk); @(negedge clk);
    check("dump_first_m_valid", 64'(m_valid), 64'd1);
    @(posedge clk); #1;
    m_ready = 1'b0;
    n = 0;
    @(negedge clk);
    while (!m_valid && n < 10) begin @(negedge clk); n++; end
    if (!m_valid) check("dump_word2_timeout", 64'(m_valid), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    @(posedge clk); #1;
    m_ready = 1'b1;
    wait_done(20, "dump");

    // reset in the middle of a 4-word LOAD_I
    push_iw(64'd0, 64'hCAFE_0001); push_iw(64'd4, 64'hCAFE_0002);
    send_cmd(OP_LI, 16'd0, 32'd4);
    send_word(64'hCAFE_0001); send_word(64'hCAFE_0002);
    s_valid = 1'b1; s_data = 64'hCAFE_0003; rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_all_zero("reset_midload");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("cmd_ready_after_midload_reset", 64'(cmd_ready), 64'd1);
    check("s_ready_idle_ignored", 64'(s_ready), 64'd0);
    repeat (4) @(posedge clk); #1;
    s_valid = 1'b0;
    repeat (3) @(negedge clk);

    check("imem_writes_drained", 64'(q_iw.size()), 64'd0);
    check("dmem_writes_drained", 64'(q_dw.size()), 64'd0);
    check("reads_drained", 64'(q_rd.size()), 64'd0);
    check("dump_words_drained", 64'(q_m.size()), 64'd0);
    check("dones_drained", 64'(q_done.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
